// File: rtl/comp_sequencer.sv
// comp_sequencer: queues layer commands and dispatches them one at a time to NUM_ENG engines
// Ports: cmd_valid/cmd_ready/cmd_sel/cmd_last command push; eng_start/eng_done engine handshake;
//   mux_sel buffer/PE mux select (0 = none); busy, done, net_done status; err sticky
//   {timeout, illegal select} cleared by err_clr; timeout_cfg watchdog limit; q_level FIFO occupancy.
// Optional COMP_WATCHDOG_EN: RUN-cycle watchdog that aborts a silent engine and flags err[1].
module comp_sequencer #(
  parameter int NUM_ENG = 4,
  parameter int SEL_W = 3,
  parameter int QDEPTH = 4,
  parameter int TO_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [SEL_W-1:0]           cmd_sel,
  input  logic                       cmd_last,
  output logic [NUM_ENG-1:0]         eng_start,
  input  logic [NUM_ENG-1:0]         eng_done,
  output logic [SEL_W-1:0]           mux_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       net_done,
  output logic [1:0]                 err,
  input  logic                       err_clr,
  input  logic [TO_W-1:0]            timeout_cfg,
  output logic [$clog2(QDEPTH):0]    q_level
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [SEL_W-1:0] NE = SEL_W'(NUM_ENG);
  localparam logic [AW:0] QD = (AW+1)'(QDEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] mem_sel [QDEPTH];
  logic mem_last [QDEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level_n;
  logic [NUM_ENG-1:0] sel_oh;
  logic cur_last, rest, push, pop, legal, hit, to_hit;
  assign cmd_ready = q_level < QD;
  assign push = cmd_valid && cmd_ready;
  // rest holds IDLE for one cycle after DRAIN so mux_sel sits at 0 before the next pop
  assign pop = state == IDLE && !rest && q_level != '0;
  assign legal = mem_sel[rp] != '0 && mem_sel[rp] <= NE;
  // mux_sel doubles as the current command's select while an operation is in flight
  assign sel_oh = NUM_ENG'(1) << (mux_sel - 1'b1);
  assign hit = state == RUN && |(eng_done & sel_oh);
  assign level_n = q_level + (AW+1)'(push) - (AW+1)'(pop);
`ifdef COMP_WATCHDOG_EN
  logic [TO_W-1:0] wd_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) wd_cnt <= '0;
    else wd_cnt <= state == RUN ? wd_cnt + 1'b1 : '0;
  assign to_hit = state == RUN && timeout_cfg != '0 && wd_cnt == timeout_cfg - 1'b1;
`else
  assign to_hit = 1'b0 & |timeout_cfg;
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (pop && legal ? LOAD : IDLE) :
              state == LOAD  ? START :
              state == START ? RUN :
              state == RUN   ? (hit || to_hit ? DRAIN : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) begin
      mem_sel[wp] <= cmd_sel;
      mem_last[wp] <= cmd_last;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      q_level <= '0;
      rest <= 1'b0;
      mux_sel <= '0;
      cur_last <= 1'b0;
      eng_start <= '0;
      done <= 1'b0;
      net_done <= 1'b0;
      err <= '0;
      busy <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      q_level <= level_n;
      rest <= state == DRAIN;
      if (pop) begin
        mux_sel <= legal ? mem_sel[rp] : '0;
        cur_last <= mem_last[rp];
      end else if (state == DRAIN) mux_sel <= '0;
      eng_start <= state == LOAD ? sel_oh : '0;
      done <= state_n == DRAIN;
      net_done <= state_n == DRAIN && cur_last;
      err[0] <= (pop && !legal) || (err[0] && !err_clr);
      err[1] <= (to_hit && !hit) || (err[1] && !err_clr);
      busy <= state_n != IDLE || level_n != '0;
    end
endmodule

// File: tb/tb_comp_sequencer.sv
// tb_comp_sequencer: table, directed and random checks of comp_sequencer against a timeline model
module tb_comp_sequencer;
  logic clk = 0, rst = 0, cmd_valid = 0, cmd_last = 0, err_clr = 0;
  logic [2:0] cmd_sel = 0;
  logic [3:0] man_done = 0, auto_done = 0, eng_done;
  logic [15:0] timeout_cfg = 0;
  logic cmd_ready, busy, done, net_done;
  logic [3:0] eng_start;
  logic [2:0] mux_sel, q_level;
  logic [1:0] err;
  assign eng_done = auto_done | man_done;
  always #5 clk = ~clk;
  comp_sequencer dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_last(cmd_last), .eng_start(eng_start), .eng_done(eng_done),
    .mux_sel(mux_sel), .busy(busy), .done(done), .net_done(net_done), .err(err),
    .err_clr(err_clr), .timeout_cfg(timeout_cfg), .q_level(q_level));
`ifdef COMP_WATCHDOG_EN
  localparam bit WD = 1;
`else
  localparam bit WD = 0;
`endif
  int nvec = 0, nerr = 0, cyc = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  // Timeline model: a legal pop at cycle p selects the mux from p+1, starts at p+2, and
  // the command completes one cycle after the first matching engine done at or after p+3.
  int q_s[$];
  bit q_l[$];
  bit act = 0, a_last = 0;
  int a_sel = 0, pop_t = 0, done_t = -1, idle_from = 0;
  logic [1:0] m_err = 0;
  always @(negedge clk) begin : model
    int sz;
    bit set0, set1;
    sz = q_s.size();
    if (!rst) begin
      q_s.delete();
      q_l.delete();
      act = 0;
      done_t = -1;
      idle_from = 0;
      m_err = 0;
      chk("rst_outputs", {eng_start, mux_sel, busy, done, net_done, err, q_level}, 0);
      chk("rst_ready", cmd_ready, 1);
    end else begin
      chk("mux_sel", mux_sel, act ? a_sel : 0);
      chk("eng_start", eng_start, (act && cyc == pop_t + 2) ? (1 << (a_sel - 1)) : 0);
      chk("done", done, act && cyc == done_t);
      chk("net_done", net_done, act && cyc == done_t && a_last);
      chk("busy", busy, act || sz != 0);
      chk("err", err, m_err);
      chk("q_level", q_level, sz);
      chk("cmd_ready", cmd_ready, sz < 4);
      set0 = 0;
      set1 = 0;
      if (act) begin
        if (done_t < 0) begin
          if (cyc >= pop_t + 3) begin
            if (eng_done[a_sel-1]) done_t = cyc + 1;
            else if (WD && timeout_cfg != 0 && cyc - (pop_t + 3) == int'(timeout_cfg) - 1) begin
              done_t = cyc + 1;
              set1 = 1;
            end
          end
        end else if (cyc == done_t) begin
          act = 0;
          idle_from = cyc + 2;
        end
      end else if (cyc >= idle_from && sz > 0) begin
        if (q_s[0] >= 1 && q_s[0] <= 4) begin
          act = 1;
          a_sel = q_s[0];
          a_last = q_l[0];
          pop_t = cyc;
          done_t = -1;
        end else set0 = 1;
        void'(q_s.pop_front());
        void'(q_l.pop_front());
      end
      if (cmd_valid && sz < 4) begin
        q_s.push_back(int'(cmd_sel));
        q_l.push_back(cmd_last);
      end
      m_err = (err_clr ? 2'b00 : m_err) | {set1, set0};
    end
    cyc++;
  end
  int ndone = 0, nstart = 0;
  bit saw_full = 0;
  logic [3:0] starts_q[$];
  int net_at[$];
  always @(negedge clk) begin
    if (rst && eng_start != 0) begin
      starts_q.push_back(eng_start);
      nstart++;
    end
    if (rst && done) begin
      ndone++;
      if (net_done) net_at.push_back(ndone);
    end
    if (q_level == 4 && !cmd_ready) saw_full = 1;
  end
  bit auto_eng = 0;
  int pend_cnt = 0;
  logic [3:0] pend = 0;
  always @(posedge clk) begin
    #2;
    auto_done = 0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) auto_done = pend;
    end
    if (auto_eng && eng_start != 0) begin
      pend = eng_start;
      pend_cnt = 3;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int s, input bit l);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      tick();
      k++;
    end
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_sel = 3'(s);
    cmd_last = l;
    tick();
    cmd_valid = 0;
  endtask
  task automatic wait_start();
    int k = 0;
    while (eng_start == 0 && k < 20) begin
      tick();
      k++;
    end
    chk("start_seen", eng_start != 0, 1);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk("idle", busy, 0);
  endtask
  typedef struct {
    logic [2:0] sel;
    bit last;
    int lat;
    bit wrong;
    logic [3:0] exp_start;
    bit exp_net;
    bit exp_err0;
  } vec_t;
  vec_t tbl[8];
  initial begin
    #800000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int base, k;
    tbl[0] = '{3'd1, 1'b0, 5, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[1] = '{3'd0, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[2] = '{3'd5, 1'b0, 0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[3] = '{3'd3, 1'b1, 2, 1'b0, 4'b0100, 1'b1, 1'b0};
    tbl[4] = '{3'd4, 1'b0, 1, 1'b1, 4'b1000, 1'b0, 1'b0};
    tbl[5] = '{3'd2, 1'b1, 4, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[6] = '{3'd7, 1'b1, 0, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[7] = '{3'd1, 1'b1, 1, 1'b1, 4'b0001, 1'b1, 1'b0};
    tick(3);
    rst = 1;
    tick(2);
    foreach (tbl[i]) begin
      base = nstart;
      push(tbl[i].sel, tbl[i].last);
      if (tbl[i].exp_start == 0) begin
        tick(3);
        chk("illegal_err0", err[0], tbl[i].exp_err0);
        chk("illegal_nostart", nstart - base, 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("err_clr", err, 0);
      end else begin
        wait_start();
        chk("tbl_start", eng_start, tbl[i].exp_start);
        man_done = tbl[i].wrong ? 4'hf : tbl[i].exp_start;
        for (int j = 0; j < tbl[i].lat; j++) begin
          tick();
          man_done = tbl[i].wrong ? ~tbl[i].exp_start : 4'h0;
        end
        tick();
        man_done = tbl[i].exp_start;
        tick();
        man_done = 0;
        chk("tbl_done", done, 1);
        chk("tbl_net_done", net_done, tbl[i].exp_net);
        tick(2);
      end
    end
    starts_q.delete();
    net_at.delete();
    saw_full = 0;
    base = ndone;
    auto_eng = 1;
    push(2, 0);
    push(3, 0);
    push(1, 0);
    push(2, 1);
    push(4, 0);
    push(1, 0);
    wait_idle();
    auto_eng = 0;
    chk("full_seen", saw_full, 1);
    chk("order_len", starts_q.size(), 6);
    if (starts_q.size() == 6) begin
      chk("order0", starts_q[0], 4'b0010);
      chk("order1", starts_q[1], 4'b0100);
      chk("order2", starts_q[2], 4'b0001);
      chk("order3", starts_q[3], 4'b0010);
      chk("order4", starts_q[4], 4'b1000);
      chk("order5", starts_q[5], 4'b0001);
    end
    chk("net_count", net_at.size(), 1);
    if (net_at.size() == 1) chk("net_index", net_at[0], base + 4);
    timeout_cfg = 8;
    base = ndone;
    push(2, 1);
    wait_start();
`ifdef COMP_WATCHDOG_EN
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk("wd_latency", k, 9);
    chk("wd_err1", err[1], 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    wait_idle();
    timeout_cfg = 0;
    base = ndone;
    push(3, 0);
    wait_start();
    tick(1000);
    chk("wd_off_nodone", ndone - base, 0);
    man_done = 4'b0100;
    tick();
    man_done = 0;
`else
    tick(30);
    chk("nowd_nodone", ndone - base, 0);
    chk("nowd_err1", err[1], 0);
    man_done = 4'b0010;
    tick();
    man_done = 0;
`endif
    wait_idle();
    timeout_cfg = 0;
    base = ndone;
    push(1, 0);
    push(2, 0);
    push(3, 1);
    wait_start();
    tick(2);
    #2;
    rst = 0;
    #1;
    chk("async_rst_outputs", {eng_start, mux_sel, busy, done, net_done, err, q_level}, 0);
    chk("async_rst_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1;
    man_done = 4'b0001;
    tick();
    man_done = 0;
    tick(10);
    chk("rst_nodone", ndone - base, 0);
    chk("rst_level", q_level, 0);
    for (int i = 0; i < 800; i++) begin
      cmd_valid = ($urandom % 3 == 0);
      cmd_sel = 3'($urandom % 8);
      cmd_last = 1'($urandom % 2);
      man_done = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      err_clr = ($urandom % 20 == 0);
      timeout_cfg = 16'($urandom % 12);
      tick();
    end
    cmd_valid = 0;
    err_clr = 0;
    k = 0;
    while (busy && k < 500) begin
      man_done = 4'($urandom);
      tick();
      k++;
    end
    man_done = 0;
    tick(3);
    chk("final_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
